store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- MEM-stage write-side companion to the writeback select path: queues stores issued by MEM and drains them to the data memory port one per accepted cycle.
- Loads in MEM compare their address against pending stores. The youngest matching store's data is forwarded, so the value picked up by the MemToReg_m writeback select is never stale.
- Sits between MEM-stage control (MemWrite_m, MemRead_m) and the data memory write port.

Parameters:
DATA_W, 32, width of store/load data
ADDR_W, 5, width of data memory word address
DEPTH, 4, number of buffer entries (power of two, >=2)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
MemWrite_m  input  1  store request from MEM stage
addr_m  input  ADDR_W  store address
wdata_m  input  DATA_W  store data
stall_m  output  1  store request refused this cycle (pipeline must hold)
MemRead_m  input  1  load in MEM stage
load_addr  input  ADDR_W  load address for forwarding lookup
fwd_hit  output  1  load matches a pending store
fwd_data  output  DATA_W  forwarded store data
mem_we  output  1  drain request to data memory
mem_addr  output  ADDR_W  drain address (head entry)
mem_wdata  output  DATA_W  drain data (head entry)
mem_ready  input  1  memory accepts the drain this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (sync, rst=1 at edge) sets head=0, tail=0, count=0 and clears all valid bits. Pending stores are discarded, including mid-drain.
- Output values after reset: mem_we=0, fwd_hit=0, fwd_data=0, full=0, empty=1.
- mem_addr and mem_wdata are don't-care while mem_we=0. The bench must not check them then.
- Push: occurs when MemWrite_m && !full at the edge. The entry is written at tail, tail increments mod DEPTH, count increments.
- stall_m = MemWrite_m && full. It is combinational, with no state change for the refused store.
- Full blocks a push even if a pop happens in the same cycle. This is deliberate: no combinational path from mem_ready to stall_m.
- Drain: mem_we = !empty. mem_addr and mem_wdata always present the head entry.
- Pop: occurs when mem_we && mem_ready at the edge. head increments mod DEPTH, count decrements, and the entry's valid bit clears.
- Simultaneous push and pop when not full and not empty: count is unchanged and both pointers advance.
- Push into an empty buffer: the entry appears on mem_we one cycle after the push edge. There is no same-cycle bypass to memory.
- Forwarding is combinational over registered valid entries only.
  - fwd_hit = MemRead_m && some valid entry has addr == load_addr.
  - Priority: the youngest entry wins, scanning from tail-1 back toward head with wrap.
  - fwd_data is the winning entry's data, otherwise 0.
- Forwarding boundary cases:
  - A store pushed in the same cycle is not forwarded; it becomes visible the next cycle.
  - An entry being popped in the current cycle still forwards in that cycle.
- Duplicate addresses are allowed. Both entries drain in order, and forwarding returns the younger one.
- Pointer wrap: the index width is clog2(DEPTH). Full and empty are distinguished only by count.
- The block does not reorder stores or merge entries.

Decomposition:
- Shared constants file holds the DATA_W and ADDR_W defaults used by the MEM/WB datapath and the writeback select.
- Natural sub-module: sb_match, a combinational youngest-first address match.
  - Inputs: valid vector, address array, data array, tail, load_addr.
  - Outputs: hit and data.
- FIFO pointer/count logic stays in store_buffer.

Test Plan:
- Reset, then check idle outputs: after rst held 2 cycles -> empty=1, full=0, count=0, mem_we=0, fwd_hit=0, fwd_data=0.
- Single store, drain latency: push addr=3, data=0x2B with mem_ready=0 -> next cycle mem_we=1, mem_addr=3, mem_wdata=0x2B. Raise mem_ready for 1 cycle -> empty=1, mem_we=0.
- Fill, stall and ordering, mem_ready=0:
  - Push addrs 1,2,3,4 (data 0x10..0x13) -> full=1, count=4.
  - Fifth store -> stall_m=1, count stays 4.
  - Drain with mem_ready=1 -> addrs 1,2,3,4 appear in order.
- Forwarding youngest wins: push addr=7 data=0x66, then addr=7 data=0x67. Load addr 7 -> fwd_hit=1, fwd_data=0x67. Load addr 8 -> fwd_hit=0, fwd_data=0.
- Same-cycle cases:
  - Load addr 5 in the same cycle a store to 5 pushes -> fwd_hit=0.
  - Repeat the load the next cycle -> fwd_hit=1.
  - With count=2, push and pop in the same cycle -> count stays 2.
  - With 6 more push/pop pairs (pointers wrap), drain order stays correct.
- Reset mid-operation: with 3 pending stores and mem_ready toggling, assert rst for 1 cycle -> next cycle empty=1, mem_we=0. None of the discarded entries is ever driven afterwards.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: datapath width and depth defaults shared by the MEM/WB stage and the store buffer
package store_buffer_pkg;
    localparam int SB_DATA_W = 32;
    localparam int SB_ADDR_W = 5;
    localparam int SB_DEPTH  = 4;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: MEM-stage store/load requests and the data memory drain port
interface store_buffer_if #(
    parameter int DATA_W = store_buffer_pkg::SB_DATA_W,
    parameter int ADDR_W = store_buffer_pkg::SB_ADDR_W,
    parameter int DEPTH  = store_buffer_pkg::SB_DEPTH
);
    logic                   MemWrite_m;
    logic [ADDR_W-1:0]      addr_m;
    logic [DATA_W-1:0]      wdata_m;
    logic                   stall_m;
    logic                   MemRead_m;
    logic [ADDR_W-1:0]      load_addr;
    logic                   fwd_hit;
    logic [DATA_W-1:0]      fwd_data;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_ready;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output MemWrite_m, addr_m, wdata_m, MemRead_m, load_addr, mem_ready,
        input  stall_m, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata, full, empty, count
    );

    modport slave (
        input  MemWrite_m, addr_m, wdata_m, MemRead_m, load_addr, mem_ready,
        output stall_m, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata, full, empty, count
    );
endinterface

// File: rtl/store_buffer_match.sv
// sb_match: youngest-first address match over the valid store buffer entries
module sb_match #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  valid,
    input  logic [ADDR_W-1:0] addr [DEPTH],
    input  logic [DATA_W-1:0] data [DEPTH],
    input  logic [IW-1:0]     tail,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);
    logic [IW-1:0] idx;

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - IW'(k);
            if (valid[idx] && addr[idx] == load_addr) begin
                hit      = 1'b1;
                hit_data = data[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store queue draining to data memory, with youngest-store load forwarding
module store_buffer import store_buffer_pkg::*; #(
    parameter int DATA_W = SB_DATA_W,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DEPTH  = SB_DEPTH
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave sb
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [IW-1:0]     head;
    logic [IW-1:0]     tail;
    logic [CW-1:0]     count_q;
    logic              push;
    logic              pop;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    // Full refuses a store even when a drain frees a slot this cycle, keeping mem_ready off the stall path.
    assign sb.full      = count_q == CW'(DEPTH);
    assign sb.empty     = count_q == '0;
    assign sb.count     = count_q;
    assign sb.stall_m   = sb.MemWrite_m && sb.full;
    assign sb.mem_we    = !sb.empty;
    assign sb.mem_addr  = addr_q[head];
    assign sb.mem_wdata = data_q[head];
    assign sb.fwd_hit   = sb.MemRead_m && hit;
    assign sb.fwd_data  = sb.fwd_hit ? hit_data : '0;
    assign push         = sb.MemWrite_m && !sb.full;
    assign pop          = sb.mem_we && sb.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                valid_q[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= sb.addr_m;
            data_q[tail] <= sb.wdata_m;
        end
    end

    sb_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_match (
        .valid    (valid_q),
        .addr     (addr_q),
        .data     (data_q),
        .tail     (tail),
        .load_addr(sb.load_addr),
        .hit      (hit),
        .hit_data (hit_data)
    );
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: queue-model scoreboard for store_buffer with directed and random stimulus
module tb_store_buffer;
    import store_buffer_pkg::*;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] a;
        logic [SB_DATA_W-1:0] d;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    st_t  exp_q [$];
    int   checks = 0;
    int   errors = 0;
    logic final_req = 1'b0;
    logic final_done = 1'b0;

    always #5 clk = ~clk;

    store_buffer_if #(.DATA_W(SB_DATA_W), .ADDR_W(SB_ADDR_W), .DEPTH(SB_DEPTH)) sbi ();

    store_buffer #(.DATA_W(SB_DATA_W), .ADDR_W(SB_ADDR_W), .DEPTH(SB_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .sb (sbi.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: exp_q holds the pending stores oldest-first; every visible output follows from it.
    always @(negedge clk) begin : mon
        logic                 hit_e;
        logic [SB_DATA_W-1:0] data_e;
        int                   n;
        hit_e  = 1'b0;
        data_e = '0;
        n      = exp_q.size();
        if (!rst) begin
            chk("count", 64'(sbi.count), 64'(n));
            chk("empty", 64'(sbi.empty), 64'(n == 0));
            chk("full", 64'(sbi.full), 64'(n == SB_DEPTH));
            chk("mem_we", 64'(sbi.mem_we), 64'(n != 0));
            chk("stall_m", 64'(sbi.stall_m), 64'(sbi.MemWrite_m && n == SB_DEPTH));
            if (sbi.MemRead_m)
                for (int i = 0; i < n; i++)
                    if (exp_q[i].a == sbi.load_addr) begin
                        hit_e  = 1'b1;
                        data_e = exp_q[i].d;
                    end
            chk("fwd_hit", 64'(sbi.fwd_hit), 64'(hit_e));
            chk("fwd_data", 64'(sbi.fwd_data), 64'(data_e));
            if (sbi.mem_we && n > 0) begin
                chk("mem_addr", 64'(sbi.mem_addr), 64'(exp_q[0].a));
                chk("mem_wdata", 64'(sbi.mem_wdata), 64'(exp_q[0].d));
                if (sbi.mem_ready) void'(exp_q.pop_front());
            end
            if (final_req && !final_done) begin
                chk("drained", 64'(n), 64'd0);
                final_done = 1'b1;
            end
        end
    end

    // One clock of stimulus; a store is recorded as pending only once its edge has passed.
    task automatic cyc(input logic we, input logic [SB_ADDR_W-1:0] a, input logic [SB_DATA_W-1:0] d,
                       input logic rd, input logic [SB_ADDR_W-1:0] la, input logic rdy, input logic r);
        logic acc;
        rst            = r;
        sbi.MemWrite_m = we;
        sbi.addr_m     = a;
        sbi.wdata_m    = d;
        sbi.MemRead_m  = rd;
        sbi.load_addr  = la;
        sbi.mem_ready  = rdy;
        acc            = we && !r && exp_q.size() < SB_DEPTH;
        @(posedge clk);
        if (r) exp_q.delete();
        else if (acc) exp_q.push_back(st_t'{a: a, d: d});
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, '0, '0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic store(input logic [SB_ADDR_W-1:0] a, input logic [SB_DATA_W-1:0] d, input logic rdy);
        cyc(1'b1, a, d, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic load(input logic [SB_ADDR_W-1:0] la);
        cyc(1'b0, '0, '0, 1'b1, la, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * SB_DEPTH && exp_q.size() > 0; i++) idle(1'b1);
    endtask

    initial begin
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        // single store: drain visible one cycle later, then one accepted pop
        store(5'd3, 32'h2B, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        // fill, refused fifth store, in-order drain
        for (int i = 0; i < SB_DEPTH; i++) store(5'(i + 1), 32'h10 + 32'(i), 1'b0);
        store(5'd9, 32'h99, 1'b0);
        store(5'd9, 32'h98, 1'b1);
        drain();
        // duplicate address, youngest forwards; miss returns zero
        store(5'd7, 32'h66, 1'b0);
        store(5'd7, 32'h67, 1'b0);
        load(5'd7);
        load(5'd8);
        drain();
        // store and load of the same address in one cycle, then the next cycle
        cyc(1'b1, 5'd5, 32'h55, 1'b1, 5'd5, 1'b0, 1'b0);
        load(5'd5);
        store(5'd6, 32'h56, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1, 5'(9 + i), 1'b1, 1'b0);
        drain();
        // reset with pending stores while mem_ready toggles
        for (int i = 0; i < 3; i++) store(5'(20 + i), 32'hC0 + 32'(i), 1'(i));
        store(5'd23, 32'hC3, 1'b0);
        idle(1'b0);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'(i));
        // random traffic with occasional resets
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
        drain();
        final_req = 1'b1;
        for (int i = 0; i < 4 && !final_done; i++) idle(1'b0);
        if (!final_done) begin
            checks++;
            errors++;
            $display("FAIL final_check got=pending want=done");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
